// File: rtl/pwm_from_counter.sv
// pwm_from_counter: PWM generator driven by an external free-running up counter,
// with a boundary-synchronised duty shadow register and a sticky sequence-error flag.
module pwm_from_counter #(
   parameter int BITS      = 4,
   parameter int INIT_DUTY = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [BITS-1:0] cnt,
   input  logic [BITS:0]   duty_in,
   input  logic            duty_valid,
   output logic            duty_ready,
   output logic            pwm,
   output logic            period_start,
   output logic            seq_err,
   input  logic            err_clr
);
   typedef enum logic {SYNC, RUN} state_t;

   localparam logic [BITS:0] FULL = {1'b1, {BITS{1'b0}}};
   localparam logic [BITS:0] INIT = (BITS+1)'(INIT_DUTY);

   state_t          state_q, state_d;
   logic [BITS:0]   duty_act_q, duty_act_d;
   logic [BITS:0]   duty_sh_q, duty_sh_d;
   logic            pend_q, pend_d;
   logic [BITS-1:0] cnt_prev_q, cnt_prev_d;
   logic            pwm_q, pwm_d;
   logic            period_start_q, period_start_d;
   logic            seq_err_q, seq_err_d;

   logic            boundary, accept, bypass, swap, skip;
   logic [BITS:0]   duty_clamp, duty_eff;

   always_comb begin
      boundary       = (cnt == '0);
      accept         = duty_valid & ~pend_q;
      bypass         = accept & boundary;
      swap           = pend_q & boundary;
      duty_clamp     = (duty_in > FULL) ? FULL : duty_in;
      // A same-cycle accept at the boundary takes effect for the period starting now.
      duty_eff       = bypass ? duty_clamp : swap ? duty_sh_q : duty_act_q;
      state_d        = (state_q == SYNC && boundary) ? RUN : state_q;
      duty_act_d     = duty_eff;
      duty_sh_d      = (accept & ~boundary) ? duty_clamp : duty_sh_q;
      pend_d         = swap ? 1'b0 : (accept & ~boundary) ? 1'b1 : pend_q;
      pwm_d          = (state_d == RUN) & ({1'b0, cnt} < duty_eff);
      period_start_d = boundary;
      skip           = (state_q == RUN) & (cnt != cnt_prev_q + BITS'(1));
      seq_err_d      = skip | (seq_err_q & ~err_clr);
      cnt_prev_d     = cnt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= SYNC;
         duty_act_q     <= INIT;
         duty_sh_q      <= INIT;
         pend_q         <= 1'b0;
         cnt_prev_q     <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         seq_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         duty_act_q     <= duty_act_d;
         duty_sh_q      <= duty_sh_d;
         pend_q         <= pend_d;
         cnt_prev_q     <= cnt_prev_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
         seq_err_q      <= seq_err_d;
      end
   end

   assign duty_ready   = ~pend_q;
   assign pwm          = pwm_q;
   assign period_start = period_start_q;
   assign seq_err      = seq_err_q;
endmodule

// File: tb/tb_pwm_from_counter.sv
// tb_pwm_from_counter: directed self-checking bench for pwm_from_counter (BITS=4, INIT_DUTY=0).
module tb_pwm_from_counter;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] cnt = '0;
   logic [4:0] duty_in = '0;
   logic       duty_valid = 1'b0;
   logic       duty_ready, pwm, period_start, seq_err;
   logic       err_clr = 1'b0;
   int         checks = 0;
   int         failures = 0;

   pwm_from_counter #(.BITS(4), .INIT_DUTY(0)) dut (
      .clk(clk), .reset_n(reset_n), .cnt(cnt), .duty_in(duty_in),
      .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm(pwm),
      .period_start(period_start), .seq_err(seq_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int c);
      cnt = 4'(c);
      @(posedge clk);
      #1;
   endtask

   // One counter period from cnt=first..last with expected duty exp_duty;
   // optionally presents a one-cycle load of load_val at cnt==load_at.
   task automatic run_period(input int exp_duty, input int first = 0, input int last = 15,
                             input int load_at = -1, input int load_val = 0);
      for (int c = first; c <= last; c++) begin
         if (c == load_at) begin
            duty_in    = 5'(load_val);
            duty_valid = 1'b1;
         end
         step(c);
         duty_valid = 1'b0;
         check("pwm", pwm, 32'(c < exp_duty));
         check("period_start", period_start, 32'(c == 0));
         check("seq_err", seq_err, 0);
      end
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #3;
      check("rst_pwm", pwm, 0);
      check("rst_ps", period_start, 0);
      check("rst_ready", duty_ready, 1);
      check("rst_seq_err", seq_err, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      // Test 1: sync from mid-count, then duty 0 periods
      for (int c = 5; c <= 15; c++) begin
         step(c);
         check("sync_pwm", pwm, 0);
         check("sync_ps", period_start, 0);
      end
      run_period(0);
      run_period(0);
      // Test 2: load 5 at cnt=9
      run_period(0, 0, 8);
      duty_in = 5'd5; duty_valid = 1'b1;
      step(9);
      duty_valid = 1'b0;
      check("t2_ready_drop", duty_ready, 0);
      check("t2_pwm_old", pwm, 0);
      run_period(0, 10, 15);
      check("t2_ready_held", duty_ready, 0);
      step(0);
      check("t2_pwm_new", pwm, 1);
      check("t2_ready_back", duty_ready, 1);
      run_period(5, 1, 15);
      run_period(5);
      // Test 3: duty 16, then 0, then 20 clamps to 16
      run_period(5, 0, 15, 4, 16);
      run_period(16, 0, 15, 2, 0);
      run_period(0, 0, 15, 3, 20);
      run_period(16);
      // Test 4: bypass at boundary, then a stalled second request
      duty_in = 5'd3; duty_valid = 1'b1;
      step(0);
      check("t4_bypass_pwm", pwm, 1);
      check("t4_bypass_ready", duty_ready, 1);
      duty_in = 5'd7;
      step(1);
      check("t4_pwm1", pwm, 1);
      check("t4_ready_acc", duty_ready, 0);
      duty_in = 5'd9;
      for (int c = 2; c <= 15; c++) begin
         step(c);
         check("t4_pwm", pwm, 32'(c < 3));
         check("t4_stall", duty_ready, 0);
      end
      step(0);
      check("t4_swap_pwm", pwm, 1);
      check("t4_swap_ready", duty_ready, 1);
      step(1);
      duty_valid = 1'b0;
      check("t4_acc9_ready", duty_ready, 0);
      for (int c = 2; c <= 15; c++) begin
         step(c);
         check("t4_pwm7", pwm, 32'(c < 7));
      end
      run_period(9);
      check("t4_ready_end", duty_ready, 1);
      // Test 5: sequence error
      run_period(9, 0, 8);
      step(10);
      check("t5_set", seq_err, 1);
      step(11);
      check("t5_sticky", seq_err, 1);
      err_clr = 1'b1;
      step(12);
      err_clr = 1'b0;
      check("t5_clr", seq_err, 0);
      step(13);
      check("t5_clear_stays", seq_err, 0);
      err_clr = 1'b1;
      step(15);
      check("t5_set_wins", seq_err, 1);
      step(0);
      err_clr = 1'b0;
      check("t5_wrap_legal", seq_err, 0);
      check("t5_wrap_ps", period_start, 1);
      for (int c = 1; c <= 5; c++) step(c);
      step(0);
      check("t5_cnt_rst_err", seq_err, 1);
      check("t5_cnt_rst_ps", period_start, 1);
      check("t5_cnt_rst_pwm", pwm, 1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("t5_clr2", seq_err, 0);
      // Test 6: own reset with a pending duty
      step(2);
      duty_in = 5'd12; duty_valid = 1'b1;
      step(3);
      duty_valid = 1'b0;
      check("t6_pend", duty_ready, 0);
      step(4);
      check("t6_pwm_pre", pwm, 1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_pwm", pwm, 0);
      check("t6_rst_ready", duty_ready, 1);
      check("t6_rst_ps", period_start, 0);
      check("t6_rst_err", seq_err, 0);
      step(5);
      reset_n = 1'b1;
      for (int c = 6; c <= 15; c++) begin
         step(c);
         check("t6_sync_pwm", pwm, 0);
      end
      run_period(0);
      run_period(0);
      check("t6_ready_end", duty_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
